// File: rtl/nest_checker_if.sv
// Character stream in, nesting status out, for the begin/end/fork/join nest checker.
interface nest_checker_if #(
  parameter int DW = 6
);
  logic          en;
  logic [7:0]    in;
  logic          result;
  logic [DW-1:0] depth;
  logic          error;
  logic          overflow;

  modport master (output en, in, input result, depth, error, overflow);
  modport slave  (input en, in, output result, depth, error, overflow);
endinterface

// File: rtl/nest_checker.sv
// Tracks begin/end and fork/join nesting in a space-delimited ASCII stream.
// Words are recognised by a prefix FSM; each keyword takes effect when its trailing space arrives.
module nest_checker #(
  parameter int DEPTH = 8,
  parameter int DW    = 6
) (
  input logic           clk,
  input logic           reset,
  nest_checker_if.slave bus
);

  typedef enum logic [4:0] {
    ST_SP, ST_B, ST_BE, ST_BEG, ST_BEGI, ST_BEGIN,
    ST_E, ST_EN, ST_END,
    ST_F, ST_FO, ST_FOR, ST_FORK,
    ST_J, ST_JO, ST_JOI, ST_JOIN,
    ST_OTHER
  } state_t;

  function automatic logic [7:0] to_lower(input logic [7:0] c);
    if (c >= 8'h41 && c <= 8'h5A) begin
      to_lower = c | 8'h20;
    end else begin
      to_lower = c;
    end
  endfunction

  state_t           state_r, state_next_s;
  logic [7:0]       lc_s;
  logic             is_space_s;
  logic             open_s, close_s, type_s;
  logic             top_s, push_s;
  logic [DW-1:0]    depth_r, depth_next_s;
  logic [DEPTH-1:0] stack_r, stack_next_s;
  logic             error_r, error_next_s;
  logic             overflow_r, overflow_next_s;

  assign lc_s       = to_lower(bus.in);
  assign is_space_s = (bus.in == 8'h20);

  // Word FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_SP;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Word FSM next state: a wrong letter anywhere drops into OTHER until the next space
  always_comb begin
    state_next_s = state_r;
    if (!bus.en) begin
      state_next_s = state_r;
    end else if (is_space_s) begin
      state_next_s = ST_SP;
    end else begin
      case (state_r)
        ST_SP: begin
          case (lc_s)
            8'h62:   state_next_s = ST_B;
            8'h65:   state_next_s = ST_E;
            8'h66:   state_next_s = ST_F;
            8'h6A:   state_next_s = ST_J;
            default: state_next_s = ST_OTHER;
          endcase
        end
        ST_B:    state_next_s = (lc_s == 8'h65) ? ST_BE    : ST_OTHER;
        ST_BE:   state_next_s = (lc_s == 8'h67) ? ST_BEG   : ST_OTHER;
        ST_BEG:  state_next_s = (lc_s == 8'h69) ? ST_BEGI  : ST_OTHER;
        ST_BEGI: state_next_s = (lc_s == 8'h6E) ? ST_BEGIN : ST_OTHER;
        ST_E:    state_next_s = (lc_s == 8'h6E) ? ST_EN    : ST_OTHER;
        ST_EN:   state_next_s = (lc_s == 8'h64) ? ST_END   : ST_OTHER;
        ST_F:    state_next_s = (lc_s == 8'h6F) ? ST_FO    : ST_OTHER;
        ST_FO:   state_next_s = (lc_s == 8'h72) ? ST_FOR   : ST_OTHER;
        ST_FOR:  state_next_s = (lc_s == 8'h6B) ? ST_FORK  : ST_OTHER;
        ST_J:    state_next_s = (lc_s == 8'h6F) ? ST_JO    : ST_OTHER;
        ST_JO:   state_next_s = (lc_s == 8'h69) ? ST_JOI   : ST_OTHER;
        ST_JOI:  state_next_s = (lc_s == 8'h6E) ? ST_JOIN  : ST_OTHER;
        default: state_next_s = ST_OTHER;
      endcase
    end
  end

  // Word FSM outputs: keyword commit decode, type 0 = begin/end, 1 = fork/join
  always_comb begin
    open_s  = 1'b0;
    close_s = 1'b0;
    type_s  = (state_r == ST_FORK) || (state_r == ST_JOIN);
    if (bus.en && is_space_s) begin
      open_s  = (state_r == ST_BEGIN) || (state_r == ST_FORK);
      close_s = (state_r == ST_END)   || (state_r == ST_JOIN);
    end else begin
      open_s  = 1'b0;
      close_s = 1'b0;
    end
  end

  // Stack and flag next-state; a mismatched closer still pops
  always_comb begin
    depth_next_s    = depth_r;
    error_next_s    = error_r;
    overflow_next_s = overflow_r;
    push_s          = 1'b0;
    top_s           = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      top_s = (depth_r == DW'(i + 1)) ? stack_r[i] : top_s;
    end
    if (open_s) begin
      if (depth_r == DW'(DEPTH)) begin
        overflow_next_s = 1'b1;
        error_next_s    = 1'b1;
      end else begin
        push_s       = 1'b1;
        depth_next_s = depth_r + DW'(1);
      end
    end else if (close_s) begin
      if (depth_r == {DW{1'b0}}) begin
        error_next_s = 1'b1;
      end else begin
        error_next_s = error_r | (top_s != type_s);
        depth_next_s = depth_r - DW'(1);
      end
    end else begin
      depth_next_s = depth_r;
    end
    for (int i = 0; i < DEPTH; i++) begin
      stack_next_s[i] = (push_s && (depth_r == DW'(i))) ? type_s : stack_r[i];
    end
  end

  // Stack, depth and sticky flag registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_r    <= {DW{1'b0}};
      stack_r    <= {DEPTH{1'b0}};
      error_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      depth_r    <= depth_next_s;
      stack_r    <= stack_next_s;
      error_r    <= error_next_s;
      overflow_r <= overflow_next_s;
    end
  end

  assign bus.depth    = depth_r;
  assign bus.error    = error_r;
  assign bus.overflow = overflow_r;
  assign bus.result   = (depth_r == {DW{1'b0}}) && !error_r;

endmodule

// File: tb/tb_nest_checker.sv
// Bench for nest_checker: a DEPTH=8 and a DEPTH=2 instance share one character stream and are
// compared against a word-level model (word buffer + per-instance type stack).
module tb_nest_checker;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  nest_checker_if #(.DW(6)) ifa ();
  nest_checker_if #(.DW(6)) ifb ();

  nest_checker #(.DEPTH(8), .DW(6)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  nest_checker #(.DEPTH(2), .DW(6)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

  // Reference model: index 0 tracks dut_a (cap 8), index 1 tracks dut_b (cap 2)
  int          mdep [2];
  bit          merr [2];
  bit          movf [2];
  bit          mstk [2][32];
  logic [63:0] wbits;
  int          wlen;

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mdep[m] = 0;
      merr[m] = 1'b0;
      movf[m] = 1'b0;
      for (int k = 0; k < 32; k++) mstk[m][k] = 1'b0;
    end
    wbits = 64'd0;
    wlen  = 0;
  endtask

  task automatic model_word();
    int kind;
    bit t;
    int cap;
    kind = 0;
    t    = 1'b0;
    if (wlen == 5 && wbits[39:0] == "begin")     begin kind = 1; t = 1'b0; end
    else if (wlen == 3 && wbits[23:0] == "end")  begin kind = 2; t = 1'b0; end
    else if (wlen == 4 && wbits[31:0] == "fork") begin kind = 1; t = 1'b1; end
    else if (wlen == 4 && wbits[31:0] == "join") begin kind = 2; t = 1'b1; end
    for (int m = 0; m < 2; m++) begin
      cap = (m == 0) ? 8 : 2;
      if (kind == 1) begin
        if (mdep[m] == cap) begin
          movf[m] = 1'b1;
          merr[m] = 1'b1;
        end else begin
          mstk[m][mdep[m]] = t;
          mdep[m]++;
        end
      end else if (kind == 2) begin
        if (mdep[m] == 0) begin
          merr[m] = 1'b1;
        end else begin
          if (mstk[m][mdep[m] - 1] != t) merr[m] = 1'b1;
          mdep[m]--;
        end
      end
    end
  endtask

  task automatic model_char(input logic [7:0] c);
    logic [7:0] lc;
    if (c == 8'h20) begin
      if (wlen > 0) model_word();
      wbits = 64'd0;
      wlen  = 0;
    end else begin
      lc = (c >= 8'h41 && c <= 8'h5A) ? (c + 8'd32) : c;
      wbits = {wbits[55:0], lc};
      if (wlen < 1000) wlen++;
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_a_depth"},  int'(ifa.depth),    mdep[0]);
    chk({tag, "_a_error"},  int'(ifa.error),    int'(merr[0]));
    chk({tag, "_a_ovf"},    int'(ifa.overflow), int'(movf[0]));
    chk({tag, "_a_result"}, int'(ifa.result),   int'(mdep[0] == 0 && !merr[0]));
    chk({tag, "_b_depth"},  int'(ifb.depth),    mdep[1]);
    chk({tag, "_b_error"},  int'(ifb.error),    int'(merr[1]));
    chk({tag, "_b_ovf"},    int'(ifb.overflow), int'(movf[1]));
    chk({tag, "_b_result"}, int'(ifb.result),   int'(mdep[1] == 0 && !merr[1]));
  endtask

  task automatic send_char(input logic [7:0] c, input logic e);
    ifa.en = e;
    ifb.en = e;
    ifa.in = c;
    ifb.in = c;
    @(posedge clk);
    #1;
    if (e) model_char(c);
    check_all(e ? "char" : "idle");
    ifa.en = 1'b0;
    ifb.en = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
  endtask

  // Reset is raised between edges so its effect is checked before any clock arrives
  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  string wl [10] = '{"begin", "end", "fork", "join", "BEGIN", "Fork", "ends", "foo", "x", "jOIn"};

  initial begin
    string w;
    ifa.en = 1'b0; ifb.en = 1'b0;
    ifa.in = 8'h00; ifb.in = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_depth", int'(ifa.depth), 0);
    chk("reset_result", int'(ifa.result), 1);
    check_all("init");
    reset = 1'b0;

    send_str("begin fork join end ");
    chk("nest_depth", int'(ifa.depth), 0);
    chk("nest_result", int'(ifa.result), 1);
    chk("nest_error", int'(ifa.error), 0);

    send_str("BeGiN foo enD ");
    chk("case_result", int'(ifa.result), 1);

    send_str("begin join ");
    chk("mismatch_error", int'(ifa.error), 1);
    chk("mismatch_depth", int'(ifa.depth), 0);
    send_str("begin end ");
    chk("sticky_error", int'(ifa.error), 1);
    chk("sticky_result", int'(ifa.result), 0);

    do_reset();
    send_str("end ");
    chk("underflow_error", int'(ifa.error), 1);
    send_str("endx begin");
    chk("partial_depth", int'(ifa.depth), 0);

    do_reset();
    send_str("begin begin begin ");
    chk("ovf_b_depth", int'(ifb.depth), 2);
    chk("ovf_b_flag", int'(ifb.overflow), 1);
    chk("ovf_a_depth", int'(ifa.depth), 3);
    send_str("end end ");
    chk("ovf_b_depth0", int'(ifb.depth), 0);
    chk("ovf_b_result", int'(ifb.result), 0);

    do_reset();
    send_str("begin fo");
    do_reset();
    send_str("rk ");
    chk("fresh_depth", int'(ifa.depth), 0);
    chk("fresh_result", int'(ifa.result), 1);

    send_str("begin");
    repeat (3) send_char(8'h20, 1'b0);
    chk("freeze_depth", int'(ifa.depth), 0);
    send_char(8'h20, 1'b1);
    chk("unfreeze_depth", int'(ifa.depth), 1);

    do_reset();
    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      w = wl[$urandom_range(0, 9)];
      for (int i = 0; i < w.len(); i++) begin
        if ($urandom_range(0, 4) == 0) send_char(8'($urandom_range(0, 255)), 1'b0);
        send_char(w[i], 1'b1);
      end
      send_char(8'h20, 1'b1);
      if ($urandom_range(0, 7) == 0) send_char(8'h20, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nest_checker.md
NEST_CHECKER -- requirements
Module: nest_checker

Interface
REQ-001 Parameter DEPTH, default 8, SHALL set the maximum nesting depth held on the type stack (legal range 2..32).
REQ-002 Parameter DW, default 6, SHALL set the width of the depth output, and SHALL satisfy 2^DW > DEPTH.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-005 Port en, input, 1 bit, SHALL qualify in: when en=0 the character is ignored and all state holds.
REQ-006 Port in, input, 8 bits, SHALL carry one ASCII character per enabled cycle.
REQ-007 Port result, output, 1 bit, SHALL be 1 when the stream so far is balanced and error-free.
REQ-008 Port depth, output, DW bits, SHALL give the current number of open blocks.
REQ-009 Port error, output, 1 bit, SHALL be a sticky flag: unmatched closer, mismatched type, or overflow.
REQ-010 Port overflow, output, 1 bit, SHALL be a sticky flag: an opener arrived while depth==DEPTH.

Function
REQ-011 Words SHALL be maximal runs of non-space characters; the only delimiter SHALL be space (8'h20).
REQ-012 Keyword matching SHALL be case-insensitive for letters only, word by word (whole-word matches only).
REQ-013 Keywords: "begin" SHALL open type B, "end" SHALL close type B, "fork" SHALL open type F, "join" SHALL close type F.
REQ-014 The word FSM SHALL have these states: SP (between words); the prefix states B, BE, BEG, BEGI, BEGIN, E, EN, END, F, FO, FOR, FORK, J, JO, JOI, JOIN; and OTHER.
REQ-015 Word FSM transitions, per enabled character:
- space -> SP, from any state.
- Next expected letter -> the next prefix state.
- Any other non-space character -> OTHER.
- OTHER stays in OTHER until a space arrives.
REQ-016 A keyword SHALL commit only when a space arrives while the FSM is in BEGIN, END, FORK or JOIN; the commit takes effect at that same clock edge.
REQ-017 A keyword not yet followed by a space SHALL have no effect ("ends" and "beginx" are ordinary words).
REQ-018 Opener commit with depth<DEPTH: the type SHALL be pushed onto the stack and depth incremented by 1.
REQ-019 Opener commit with depth==DEPTH: the stack and depth SHALL hold, and overflow and error SHALL both be set.
REQ-020 Closer commit with depth==0: depth SHALL hold and error SHALL be set.
REQ-021 Closer commit whose type differs from the top of stack: error SHALL be set, the entry SHALL still be popped, and depth decremented.
REQ-022 Closer commit whose type matches the top of stack: the entry SHALL be popped and depth decremented, with no flag change.
REQ-023 Once set, error and overflow SHALL remain 1 until reset; all subsequent commits SHALL still update the stack and depth.
REQ-024 result SHALL be combinational: result = (depth==0) && !error.
REQ-025 depth SHALL never wrap below 0 or above DEPTH.

Reset
REQ-026 Reset SHALL force, immediately and regardless of clk or en: the word FSM to SP, depth=0, stack cleared, error=0, overflow=0, result=1.
REQ-027 Reset asserted mid-word or mid-block SHALL discard all partial state; the first word after release SHALL be treated as a fresh word.

Verification
REQ-028 Stream "begin fork join end " with en=1 -> depth 1,2,1,0 after each trailing space; result=1 at the end; error=0.
REQ-029 Stream "BeGiN foo enD " -> depth 1 then 0; result=1; "foo" has no effect.
REQ-030 Stream "begin join " -> error=1 after the second space; depth=0; result=0; error stays 1 after a further "begin end ".
REQ-031 Stream "end " -> error=1 and depth=0; then "endx begin" with no trailing space -> depth stays 0.
REQ-032 With DEPTH=2, stream "begin begin begin " -> depth=2 and overflow=1, error=1 after the third space; then "end end " -> depth=0 and result=0.
REQ-033 Assert reset after "begin fo", then send "rk " -> depth=0, error=0, result=1 immediately on reset and after the stream; also check that holding en=0 freezes all state for 3 cycles.
